// File: rtl/fn_eval_sched.sv
// Round-robin scheduler feeding a shared two-stage function evaluator.
// S1 holds the granted request; S2 holds the tagged result.
module fn_eval_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic [IDW-1:0]    res_id,
    output logic              res_err
);

    logic           s1_v_q;
    logic [2:0]     s1_op_q, s1_op_d;
    logic [7:0]     s1_a_q, s1_a_d;
    logic [7:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s2_v_q;
    logic [7:0]     s2_data_q, s2_data_d;
    logic [IDW-1:0] s2_id_q;
    logic           s2_err_q, s2_err_d;

    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic            adv2;
    logic            s1_free;
    logic [3:0]      t4;

    assign adv2    = !s2_v_q || res_ready;
    assign s1_free = !s1_v_q || adv2;

    // Search outward from ptr: distance k, requester i, first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        ptr_d   = ptr_q;
        s1_op_d = '0;
        s1_a_d  = '0;
        s1_b_d  = '0;
        s1_id_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (s1_free && !gnt_any && req_valid[i] &&
                    ((int'(ptr_q) + k == i) ||
                     (int'(ptr_q) + k == i + NREQ))) begin
                    gnt_any = 1'b1;
                    gnt[i]  = 1'b1;
                    s1_op_d = req_op[3*i +: 3];
                    s1_a_d  = req_a[8*i +: 8];
                    s1_b_d  = req_b[8*i +: 8];
                    s1_id_d = IDW'(i);
                    ptr_d   = (i == NREQ - 1) ? '0 : IDW'(i + 1);
                end
            end
        end
    end

    assign req_ready = rst ? '0 : gnt;

    always_comb begin
        t4        = s1_a_q[3:0] & s1_b_q[3:0];
        s2_data_d = 8'h00;
        s2_err_d  = 1'b0;
        unique case (s1_op_q)
            3'd0: s2_data_d = {8{s1_a_q[0] ^ s1_b_q[0]}};
            3'd1,
            3'd3: s2_data_d = {7'b0, s1_a_q[0] & s1_b_q[0]};
            3'd2: s2_data_d = {{4{t4[3]}}, t4};
            3'd4: s2_data_d = {7'b0,
                      $signed(s1_a_q[3:0]) < $signed(s1_b_q[3:0])};
            default: s2_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_op_q   <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_id_q   <= '0;
            ptr_q     <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= 8'h00;
            s2_id_q   <= '0;
            s2_err_q  <= 1'b0;
        end else begin
            if (adv2) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_data_q <= s2_data_d;
                    s2_id_q   <= s1_id_q;
                    s2_err_q  <= s2_err_d;
                end
            end
            if (s1_free) begin
                s1_v_q <= gnt_any;
                if (gnt_any) begin
                    s1_op_q <= s1_op_d;
                    s1_a_q  <= s1_a_d;
                    s1_b_q  <= s1_b_d;
                    s1_id_q <= s1_id_d;
                    ptr_q   <= ptr_d;
                end
            end
        end
    end

    assign res_valid = s2_v_q;
    assign res_data  = s2_data_q;
    assign res_id    = s2_id_q;
    assign res_err   = s2_err_q;

endmodule

// File: tb/tb_fn_eval_sched.sv
// Bench for fn_eval_sched: scenario tasks checked against a
// transaction-queue reference model.
module tb_fn_eval_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_err;

    int total = 0;
    int bad   = 0;

    fn_eval_sched #(.NREQ(4), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] d;
        logic       e;
        int         age;
    } item_t;

    item_t q[$];
    int    ptr_m = 0;

    function automatic logic [7:0] ref_eval(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        int ai, bi, t, sa, sb;
        ai = int'(a);
        bi = int'(b);
        case (op)
            3'd0: return ((ai % 2) != (bi % 2)) ? 8'hFF : 8'h00;
            3'd1, 3'd3: return ((ai % 2) == 1 && (bi % 2) == 1) ? 8'h01 : 8'h00;
            3'd2: begin
                t = (ai % 16) & (bi % 16);
                return (t >= 8) ? 8'(t + 240) : 8'(t);
            end
            3'd4: begin
                sa = ai % 16;
                sb = bi % 16;
                if (sa >= 8) sa = sa - 16;
                if (sb >= 8) sb = sb - 16;
                return (sa < sb) ? 8'h01 : 8'h00;
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] exp_grant();
        int i;
        if (rst) return 4'b0000;
        if (q.size() >= 2 && !res_ready) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            i = (ptr_m + k) % 4;
            if (req_valid[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    function automatic logic exp_v();
        return q.size() > 0 && q[0].age >= 2;
    endfunction

    function automatic logic [10:0] exp_o();
        if (q.size() == 0) return 11'h0;
        return {q[0].d, 2'(q[0].id), q[0].e};
    endfunction

    task automatic tick();
        logic [3:0]  g;
        logic        pop;
        logic        r;
        logic [11:0] op_s;
        logic [31:0] a_s, b_s;
        item_t       it;
        g    = exp_grant() & req_valid;
        pop  = exp_v() && res_ready;
        r    = rst;
        op_s = req_op;
        a_s  = req_a;
        b_s  = req_b;
        @(posedge clk);
        if (r) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (pop) void'(q.pop_front());
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    it.id  = i;
                    it.d   = ref_eval(op_s[3*i +: 3], a_s[8*i +: 8], b_s[8*i +: 8]);
                    it.e   = op_s[3*i +: 3] >= 3'd5;
                    it.age = 0;
                    q.push_back(it);
                    ptr_m = (i + 1) % 4;
                end
            end
            for (int j = 0; j < q.size(); j++) q[j].age++;
        end
        @(negedge clk);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 4; i++) begin
            req_op[3*i +: 3] = 3'($urandom_range(0, 7));
            req_a[8*i +: 8]  = 8'($urandom);
            req_b[8*i +: 8]  = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0000", req_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({res_valid, res_data, res_id, res_err} !== 12'h000) begin
            bad++;
            $display("FAIL reset_out got=%b/%h/%0d/%b want=0/00/0/0",
                     res_valid, res_data, res_id, res_err);
        end
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant got=%b want=0001", req_ready);
        end
        req_valid = 4'h0;
        #1;
        tick();
    endtask

    task automatic test_single();
        req_valid = 4'b0010;
        req_op[5:3] = 3'd2;
        req_a[15:8] = 8'h0C;
        req_b[15:8] = 8'h0A;
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL single_grant got=%b want=0010", req_ready);
        end
        tick();
        req_valid = 4'h0;
        #1;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early got=%b want=0", res_valid);
        end
        tick();
        #1;
        total++;
        if ({res_valid, res_data, res_id, res_err} !== {1'b1, 8'hF8, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL single_res got=%b/%h/%0d/%b want=1/f8/1/0",
                     res_valid, res_data, res_id, res_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd4};
        logic [7:0] as  [5] = '{8'h01, 8'hFF, 8'h01, 8'h08, 8'h07};
        logic [7:0] bs  [5] = '{8'h00, 8'h01, 8'h0F, 8'h07, 8'h08};
        logic [7:0] ex  [5] = '{8'hFF, 8'h01, 8'h01, 8'h01, 8'h00};
        res_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                req_valid = 4'b0001;
                req_op[2:0] = ops[k];
                req_a[7:0] = as[k];
                req_b[7:0] = bs[k];
            end else begin
                req_valid = 4'h0;
            end
            #1;
            if (k < 5) begin
                total++;
                if (req_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL b2b_grant k=%0d got=%b want=0001", k, req_ready);
                end
            end
            if (k >= 2) begin
                total++;
                if ({res_valid, res_data, res_id, res_err} !== {1'b1, ex[k-2], 2'd0, 1'b0}) begin
                    bad++;
                    $display("FAIL b2b_res k=%0d got=%b/%h/%0d/%b want=1/%h/0/0",
                             k, res_valid, res_data, res_id, res_err, ex[k-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        req_valid = 4'h0;
        res_ready = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            req_valid = (k < 6) ? 4'hF : 4'h0;
            rand_fields();
            #1;
            if (k < 6) begin
                total++;
                if (req_ready !== 4'(1 << (k % 4))) begin
                    bad++;
                    $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, 4'(1 << (k % 4)));
                end
            end
            if (k >= 2 && k < 8) begin
                total++;
                if (res_valid !== 1'b1 || res_id !== 2'((k - 2) % 4) ||
                    {res_data, res_id, res_err} !== exp_o()) begin
                    bad++;
                    $display("FAIL rr_res k=%0d got=%b/%h/%0d/%b want=1/%h/%0d",
                             k, res_valid, res_data, res_id, res_err, exp_o(), (k - 2) % 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int drained = 0;
        res_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rand_fields();
            #1;
            if ((req_ready & req_valid) != 4'h0) acc++;
            total++;
            if (res_valid !== exp_v() || (exp_v() && {res_data, res_id, res_err} !== exp_o())) begin
                bad++;
                $display("FAIL bp_hold k=%0d got=%b/%h/%0d/%b want=%b/%h",
                         k, res_valid, res_data, res_id, res_err, exp_v(), exp_o());
            end
            tick();
        end
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL bp_accepts got=%0d want=2", acc);
        end
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL bp_ready_block got=%b want=0000", req_ready);
        end
        req_valid = 4'h0;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (res_valid !== exp_v() || (exp_v() && {res_data, res_id, res_err} !== exp_o())) begin
                bad++;
                $display("FAIL bp_drain k=%0d got=%b/%h/%0d/%b want=%b/%h",
                         k, res_valid, res_data, res_id, res_err, exp_v(), exp_o());
            end
            if (res_valid === 1'b1) drained++;
            tick();
        end
        total++;
        if (drained != 2) begin
            bad++;
            $display("FAIL bp_drained got=%0d want=2", drained);
        end
    endtask

    task automatic test_illegal();
        res_ready = 1'b1;
        req_valid = 4'b0100;
        req_op[8:6] = 3'd6;
        req_a[23:16] = 8'h55;
        req_b[23:16] = 8'hAA;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL illegal_grant got=%b want=0100", req_ready);
        end
        tick();
        req_valid = 4'h0;
        #1;
        tick();
        #1;
        total++;
        if ({res_valid, res_data, res_id, res_err} !== {1'b1, 8'h00, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL illegal_res got=%b/%h/%0d/%b want=1/00/2/1",
                     res_valid, res_data, res_id, res_err);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 304; k++) begin
            req_valid = (k < 300) ? 4'($urandom) : 4'h0;
            res_ready = (k < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
            rand_fields();
            #1;
            total++;
            if (req_ready !== exp_grant()) begin
                bad++;
                $display("FAIL rand_grant k=%0d got=%b want=%b", k, req_ready, exp_grant());
            end
            total++;
            if (res_valid !== exp_v() || (exp_v() && {res_data, res_id, res_err} !== exp_o())) begin
                bad++;
                $display("FAIL rand_out k=%0d got=%b/%h/%0d/%b want=%b/%h",
                         k, res_valid, res_data, res_id, res_err, exp_v(), exp_o());
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'hF;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_fields();
            #1;
            tick();
        end
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_full got=%b want=1", res_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mid_rst_ready got=%b want=0000", req_ready);
        end
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        #1;
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_res_valid got=%b want=0", res_valid);
        end
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_grant got=%b want=0001", req_ready);
        end
        req_valid = 4'h0;
        #1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'h0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
